// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sweeps a contiguous RAM address window and presents the
// words as a valid/ready stream. It absorbs the RAM's one-cycle read latency
// with a 2-entry output FIFO and an in-flight flag. Reads are issued only when
// there is guaranteed room for the returning word, so the FIFO cannot overflow.

module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  inflight_q;

    // Output FIFO: two entries, pointer-based
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            buf_count_q;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  last_word;
    logic [2:0]            occupancy;
    logic [2:0]            occ_after_pop;

    // Stream outputs come straight from the FIFO head
    assign valid_o         = (buf_count_q != 2'd0);
    assign data_o          = buf_q[rd_ptr_q];
    assign last_o          = last_word;
    assign ram_read_addr_o = addr_cnt_q;

    // Handshake, read-issue and last-word decode
    always_comb begin
        push          = inflight_q;
        pop           = valid_o & ready_i;
        occupancy     = {1'b0, buf_count_q} + {2'b00, inflight_q};
        // pop implies buf_count >= 1, so this never underflows
        occ_after_pop = occupancy - {2'b00, pop};
        issue         = (state_q == StRun) && (remaining_q != '0) && (occ_after_pop < 3'd2);
        // Head is the final word once nothing is left to read or in flight
        last_word     = (state_q == StRun) && (remaining_q == '0) && !inflight_q &&
                        (buf_count_q == 2'd1);
    end

    // Control FSM with address/length counters and registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_cnt_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_o     <= 1'b0;
            if (issue) begin
                // Address wraps naturally at 2**ADDR_WIDTH
                addr_cnt_q  <= addr_cnt_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - (ADDR_WIDTH + 1)'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (length_i == '0) begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end else begin
                            addr_cnt_q  <= base_addr_i;
                            remaining_q <= length_i;
                            busy_o      <= 1'b1;
                            state_q     <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (pop && last_word) begin
                        state_q <= StDone;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end
                StDone: begin
                    // start_i deliberately ignored here
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output FIFO: capture returning read data, advance on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            buf_count_q <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= ram_read_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                buf_count_q <= buf_count_q + 2'd1;
            end else if (!push && pop) begin
                buf_count_q <= buf_count_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: RAM model, scoreboard queue and monitor.
module tb_ram_stream_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   length_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] ram_read_addr_o;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic          last_o;

    logic [DW-1:0] mem [16];
    logic [8:0]    exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    bit            rand_ready = 1'b0;

    ram_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .length_i       (length_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ram_read_addr_o(ram_read_addr_o),
        .ram_read_data_i(ram_q),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .last_o         (last_o)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    end
    always @(posedge clk) ram_q <= mem[ram_read_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " busy"}, busy_o, 0);
        check({name, " done"}, done_o, 0);
        check({name, " valid"}, valid_o, 0);
        check({name, " last"}, last_o, 0);
        check({name, " data"}, data_o, 0);
        check({name, " addr"}, ram_read_addr_o, 0);
    endtask

    task automatic push_window(input logic [3:0] b, input int len);
        for (int i = 0; i < len; i++) begin
            logic [3:0] a;
            a = b + 4'(i);
            exp_q.push_back({(i == len - 1), 8'h10 + {4'h0, a}});
        end
    endtask

    // Returns just after the start-sampling edge E0
    task automatic start_cmd(input logic [3:0] b, input logic [4:0] l);
        @(posedge clk); #1;
        start_i     = 1'b1;
        base_addr_i = b;
        length_i    = l;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            if (rand_ready) ready_i = 1'($urandom_range(0, 1));
            n++;
        end
        check({name, " done seen"}, done_o, 1);
        check({name, " busy at done"}, busy_o, 0);
        @(posedge clk); #1;
        check({name, " done one cycle"}, done_o, 0);
        check({name, " words left"}, exp_q.size(), 0);
        rand_ready = 1'b0;
        ready_i    = 1'b1;
    endtask

    // Monitor: scoreboard pops, hold-stability under backpressure, done counting
    initial begin
        logic          stall;
        logic [DW-1:0] hold_data;
        logic          hold_last;
        logic [8:0]    e;
        stall = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold valid", valid_o, 1);
                    check("hold data", data_o, hold_data);
                    check("hold last", last_o, hold_last);
                end
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected word: got %0h expected none", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream data", data_o, e[7:0]);
                        check("stream last", last_o, e[8]);
                    end
                end
                stall     = valid_o && !ready_i;
                hold_data = data_o;
                hold_last = last_o;
                if (done_o) done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        #2;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: base=2 len=4, latency and consecutive words
        push_window(4'd2, 4);
        start_cmd(4'd2, 5'd4);
        check("t1 busy", busy_o, 1);
        check("t1 addr E0", ram_read_addr_o, 2);
        check("t1 valid E0", valid_o, 0);
        @(posedge clk); #1;
        check("t1 valid E1", valid_o, 0);
        check("t1 addr E1", ram_read_addr_o, 3);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check("t1 valid", valid_o, 1);
            check("t1 data", data_o, 8'h12 + 8'(k));
            check("t1 last", last_o, (k == 3));
            @(posedge clk); #1;
        end
        wait_done("t1", 50);

        // 2: address wrap base=14 len=4
        push_window(4'd14, 4);
        start_cmd(4'd14, 5'd4);
        check("t2 addr 14", ram_read_addr_o, 14);
        @(posedge clk); #1;
        check("t2 addr 15", ram_read_addr_o, 15);
        @(posedge clk); #1;
        check("t2 addr 0", ram_read_addr_o, 0);
        check("t2 first data", data_o, 8'h1e);
        @(posedge clk); #1;
        check("t2 addr 1", ram_read_addr_o, 1);
        wait_done("t2", 50);

        // 3: random backpressure base=0 len=8
        push_window(4'd0, 8);
        rand_ready = 1'b1;
        start_cmd(4'd0, 5'd8);
        wait_done("t3", 400);

        // 4: zero length, plus start pulsed during DONE
        dc = done_cnt;
        start_cmd(4'd5, 5'd0);
        check("t4 done", done_o, 1);
        check("t4 busy", busy_o, 0);
        check("t4 valid", valid_o, 0);
        start_i     = 1'b1;
        base_addr_i = 4'd5;
        length_i    = 5'd2;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("t4 done pulse", done_o, 0);
        for (int k = 0; k < 4; k++) begin
            check("t4 idle valid", valid_o, 0);
            check("t4 idle busy", busy_o, 0);
            @(posedge clk); #1;
        end
        check("t4 done count", done_cnt, dc + 1);

        // 5: full window with an ignored mid-run start
        push_window(4'd0, 16);
        start_cmd(4'd0, 5'd16);
        repeat (3) @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = 4'd9;
        length_i    = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done("t5", 100);

        // 6: reset after 2 words, then a fresh command
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b0, 8'h11});
        dc = done_cnt;
        start_cmd(4'd0, 5'd6);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("t6 async reset");
        check("t6 words before reset", exp_q.size(), 0);
        @(posedge clk); #1;
        check("t6 no done", done_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6 done count", done_cnt, dc);
        push_window(4'd3, 2);
        start_cmd(4'd3, 5'd2);
        wait_done("t6", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
